// File: rtl/weight_dma_multibank_pkg.sv
// Shared types and helpers for the multi-bank weight DMA.
package weight_dma_multibank_pkg;

    localparam int unsigned DEF_NUM_FC_BANKS = 4;
    localparam int unsigned SEL_W            = DEF_NUM_FC_BANKS + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_FC    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } wdma_state_t;

    // conv words land 1:1 in the conv bank, so at most 2^bank_aw of them fit
    function automatic logic conv_len_overflow(input logic [63:0] conv_len,
                                               input int unsigned bank_aw);
        return conv_len > (64'd1 << bank_aw);
    endfunction

    // ceil(fc_len / n) > 2^aw is the same as fc_len > n * 2^aw, so no divider is needed
    function automatic logic fc_len_overflow(input logic [63:0] fc_len,
                                             input int unsigned num_fc_banks,
                                             input int unsigned bank_aw);
        return fc_len > (64'(num_fc_banks) << bank_aw);
    endfunction

endpackage

// File: rtl/wdma_tag_pipe.sv
// Read-tag delay line: carries {sel, addr} of each source read until its data returns.
module wdma_tag_pipe
    import weight_dma_multibank_pkg::*;
#(
    parameter int unsigned SW      = SEL_W,
    parameter int unsigned BANK_AW = 11,
    parameter int unsigned DEPTH   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [SW-1:0]      i_sel,
    input  logic [BANK_AW-1:0] i_addr,
    output logic               o_valid,
    output logic [SW-1:0]      o_sel,
    output logic [BANK_AW-1:0] o_addr,
    output logic               o_empty_next
);

    logic [DEPTH-1:0]   vld;
    logic [SW-1:0]      sel_q  [DEPTH];
    logic [BANK_AW-1:0] addr_q [DEPTH];
    logic               inner_busy;

    // Shift valid bits every cycle; payload only moves with a valid entry so the head holds its last tag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                sel_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            vld[0] <= i_valid & ~i_flush;
            if (i_valid & ~i_flush) begin
                sel_q[0]  <= i_sel;
                addr_q[0] <= i_addr;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1] & ~i_flush;
                if (vld[i-1] & ~i_flush) begin
                    sel_q[i]  <= sel_q[i-1];
                    addr_q[i] <= addr_q[i-1];
                end
            end
        end
    end

    // Any entry behind the output stage still in flight
    always_comb begin
        inner_busy = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            inner_busy = inner_busy | vld[i];
        end
    end

    assign o_valid      = vld[DEPTH-1];
    assign o_sel        = sel_q[DEPTH-1];
    assign o_addr       = addr_q[DEPTH-1];
    // Only the output stage (if anything) remains, so the pipe is empty after this cycle
    assign o_empty_next = ~i_valid & ~inner_busy;

endmodule

// File: rtl/weight_dma_multibank.sv
// Weight DMA: streams conv + FC weights from the source SRAM into one conv bank and NUM_FC_BANKS FC banks.
module weight_dma_multibank
    import weight_dma_multibank_pkg::*;
#(
    parameter int unsigned DW           = 16,
    parameter int unsigned AW           = 16,
    parameter int unsigned NUM_FC_BANKS = DEF_NUM_FC_BANKS,
    parameter int unsigned BANK_AW      = 11,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [AW-1:0]           i_src_base,
    input  logic [AW-1:0]           i_conv_len,
    input  logic [AW-1:0]           i_fc_len,
    output logic [AW-1:0]           o_src_addr,
    output logic                    o_src_rd,
    input  logic [DW-1:0]           i_src_data,
    output logic                    o_wr_en,
    output logic [NUM_FC_BANKS:0]   o_wr_sel,
    output logic [BANK_AW-1:0]      o_wr_addr,
    output logic [DW-1:0]           o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int unsigned BSEL_W = NUM_FC_BANKS + 1;

    wdma_state_t         state;
    logic [BSEL_W-1:0]   req_sel;
    logic [BANK_AW-1:0]  req_addr;
    logic [AW-1:0]       conv_rem;
    logic [AW-1:0]       fc_rem;
    logic [AW-1:0]       fc_len_q;
    logic                len_ovf_c;
    logic                pipe_empty_next;
    logic [DW-1:0]       wr_data_hold;

    assign len_ovf_c = conv_len_overflow(64'(i_conv_len), BANK_AW)
                     | fc_len_overflow(64'(i_fc_len), NUM_FC_BANKS, BANK_AW);

    // Control FSM; also issues one source read per cycle together with its bank tag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_src_rd   <= 1'b0;
            o_src_addr <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            req_sel    <= '0;
            req_addr   <= '0;
            conv_rem   <= '0;
            fc_rem     <= '0;
            fc_len_q   <= '0;
        end else if (i_abort) begin
            state    <= ST_IDLE;
            o_src_rd <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        o_done   <= 1'b0;
                        o_err    <= 1'b0;
                        fc_len_q <= i_fc_len;
                        if (len_ovf_c) begin
                            o_err <= 1'b1;
                            state <= ST_IDLE;
                        end else if (i_conv_len != '0) begin
                            state      <= ST_CONV;
                            o_busy     <= 1'b1;
                            o_src_rd   <= 1'b1;
                            o_src_addr <= i_src_base;
                            req_sel    <= BSEL_W'(1);
                            req_addr   <= '0;
                            conv_rem   <= i_conv_len - AW'(1);
                        end else if (i_fc_len != '0) begin
                            state      <= ST_FC;
                            o_busy     <= 1'b1;
                            o_src_rd   <= 1'b1;
                            o_src_addr <= i_src_base;
                            req_sel    <= BSEL_W'(2);
                            req_addr   <= '0;
                            fc_rem     <= i_fc_len - AW'(1);
                        end else begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                ST_CONV: begin
                    if (conv_rem != '0) begin
                        o_src_addr <= o_src_addr + AW'(1);
                        req_addr   <= req_addr + BANK_AW'(1);
                        conv_rem   <= conv_rem - AW'(1);
                    end else if (fc_len_q != '0) begin
                        state      <= ST_FC;
                        o_src_addr <= o_src_addr + AW'(1);
                        req_sel    <= BSEL_W'(2);
                        req_addr   <= '0;
                        fc_rem     <= fc_len_q - AW'(1);
                    end else begin
                        state    <= ST_DRAIN;
                        o_src_rd <= 1'b0;
                    end
                end
                ST_FC: begin
                    if (fc_rem != '0) begin
                        o_src_addr <= o_src_addr + AW'(1);
                        fc_rem     <= fc_rem - AW'(1);
                        // Rotate through the FC banks; the row address advances once per full sweep
                        if (req_sel[BSEL_W-1]) begin
                            req_sel  <= BSEL_W'(2);
                            req_addr <= req_addr + BANK_AW'(1);
                        end else begin
                            req_sel <= req_sel << 1;
                        end
                    end else begin
                        state    <= ST_DRAIN;
                        o_src_rd <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty_next) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wdma_tag_pipe #(
        .SW      (BSEL_W),
        .BANK_AW (BANK_AW),
        .DEPTH   (RD_LAT)
    ) u_tag_pipe (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_abort),
        .i_valid      (o_src_rd),
        .i_sel        (req_sel),
        .i_addr       (req_addr),
        .o_valid      (o_wr_en),
        .o_sel        (o_wr_sel),
        .o_addr       (o_wr_addr),
        .o_empty_next (pipe_empty_next)
    );

    // Remember the last written word so the data bus holds while no write is in progress
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_data_hold <= '0;
        end else if (o_wr_en) begin
            wr_data_hold <= i_src_data;
        end
    end

    // Source data arrives in the same cycle as its tag, so it is forwarded straight to the bank
    assign o_wr_data = o_wr_en ? i_src_data : wr_data_hold;

endmodule

// File: tb/tb_weight_dma_multibank.sv
// Directed bench for weight_dma_multibank: one RD_LAT=1 instance and one RD_LAT=3 instance.
module tb_weight_dma_multibank;
    import weight_dma_multibank_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned NFC = DEF_NUM_FC_BANKS;
    localparam int unsigned BAW = 11;
    localparam int unsigned SW  = SEL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort;
    logic [AW-1:0] base, conv_len, fc_len;

    logic [AW-1:0] a_addr, b_addr;
    logic          a_rd, b_rd, a_we, b_we;
    logic [DW-1:0] a_sdata, b_sdata, b_d1, b_d2, a_wdata, b_wdata;
    logic [SW-1:0] a_sel, b_sel;
    logic [BAW-1:0] a_waddr, b_waddr;
    logic          a_busy, b_busy, a_done, b_done, a_err, b_err;

    weight_dma_multibank #(.DW(DW), .AW(AW), .NUM_FC_BANKS(NFC), .BANK_AW(BAW), .RD_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_src_base(base),
        .i_conv_len(conv_len), .i_fc_len(fc_len), .o_src_addr(a_addr), .o_src_rd(a_rd),
        .i_src_data(a_sdata), .o_wr_en(a_we), .o_wr_sel(a_sel), .o_wr_addr(a_waddr),
        .o_wr_data(a_wdata), .o_busy(a_busy), .o_done(a_done), .o_err(a_err));

    weight_dma_multibank #(.DW(DW), .AW(AW), .NUM_FC_BANKS(NFC), .BANK_AW(BAW), .RD_LAT(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_src_base(base),
        .i_conv_len(conv_len), .i_fc_len(fc_len), .o_src_addr(b_addr), .o_src_rd(b_rd),
        .i_src_data(b_sdata), .o_wr_en(b_we), .o_wr_sel(b_sel), .o_wr_addr(b_waddr),
        .o_wr_data(b_wdata), .o_busy(b_busy), .o_done(b_done), .o_err(b_err));

    // Source SRAM models: word = address ^ 0xA5A5, returned 1 and 3 cycles after the read
    always @(posedge clk) begin
        if (a_rd) a_sdata <= a_addr ^ 16'hA5A5;
        b_d1    <= b_addr ^ 16'hA5A5;
        b_d2    <= b_d1;
        b_sdata <= b_d2;
    end

    // Observed-instance select
    logic           use3;
    logic           s_rd, s_we, s_busy, s_done, s_err;
    logic [AW-1:0]  s_addr;
    logic [SW-1:0]  s_sel;
    logic [BAW-1:0] s_waddr;
    logic [DW-1:0]  s_wdata;
    always_comb begin
        if (use3) begin
            s_rd = b_rd; s_we = b_we; s_busy = b_busy; s_done = b_done; s_err = b_err;
            s_addr = b_addr; s_sel = b_sel; s_waddr = b_waddr; s_wdata = b_wdata;
        end else begin
            s_rd = a_rd; s_we = a_we; s_busy = a_busy; s_done = a_done; s_err = a_err;
            s_addr = a_addr; s_sel = a_sel; s_waddr = a_waddr; s_wdata = a_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-run capture
    int             n_rd, n_wr, done_c;
    logic           err1;
    logic [AW-1:0]  rd_addr [64];
    int             rd_c    [64];
    logic [SW-1:0]  wr_sel  [64];
    logic [BAW-1:0] wr_addr [64];
    logic [DW-1:0]  wr_data [64];
    int             wr_c    [64];
    logic           busy_log [64];

    // Start a transfer and log ncyc cycles; abort_at 0 = with the start, -1 = never
    task automatic run(input logic u3, input logic [AW-1:0] b, c, f,
                       input int ncyc, input int abort_at, input int restart_at);
        use3 = u3;
        @(negedge clk);
        base = b; conv_len = c; fc_len = f;
        start = 1'b1;
        abort = (abort_at == 0);
        n_rd = 0; n_wr = 0; done_c = 0; err1 = 1'b0;
        for (int cy = 1; cy <= ncyc; cy++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (s_rd && n_rd < 64) begin
                rd_addr[n_rd] = s_addr; rd_c[n_rd] = cy; n_rd++;
            end
            if (s_we && n_wr < 64) begin
                wr_sel[n_wr] = s_sel; wr_addr[n_wr] = s_waddr;
                wr_data[n_wr] = s_wdata; wr_c[n_wr] = cy; n_wr++;
            end
            if (s_done && done_c == 0) done_c = cy;
            if (cy == 1) err1 = s_err;
            if (cy < 64) busy_log[cy] = s_busy;
            if (cy == abort_at) abort = 1'b1;
            if (cy == restart_at) start = 1'b1;
        end
    endtask

    logic [SW-1:0]  t1_sel  [11] = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd2, 5'd4, 5'd8, 5'd16};
    logic [BAW-1:0] t1_addr [11] = '{11'd0, 11'd1, 11'd2, 11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd1, 11'd1};
    logic [AW-1:0]  t2_rd   [5]  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    logic [SW-1:0]  t2_sel  [5]  = '{5'd2, 5'd4, 5'd8, 5'd16, 5'd2};
    logic [BAW-1:0] t2_addr [5]  = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd1};
    logic [DW-1:0]  t2_data [5]  = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4, 16'hA5A7};
    logic [SW-1:0]  t5_sel  [20] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1,
                                     5'd2, 5'd4, 5'd8, 5'd16, 5'd2, 5'd4, 5'd8, 5'd16, 5'd2, 5'd4};
    logic [BAW-1:0] t5_addr [20] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd8, 11'd9,
                                     11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd1, 11'd1, 11'd2, 11'd2};

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; use3 = 1'b0;
        base = '0; conv_len = '0; fc_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd",    32'(a_rd),    32'd0);
        check("rst_we",    32'(a_we),    32'd0);
        check("rst_addr",  32'(a_addr),  32'd0);
        check("rst_sel",   32'(a_sel),   32'd0);
        check("rst_wdata", 32'(a_wdata), 32'd0);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_err",   32'(a_err),   32'd0);
        check("rst3_we",   32'(b_we),    32'd0);
        rst = 1'b0;

        // RD_LAT=3, FC only, source address wraps
        run(1'b1, 16'hFFFE, 16'd0, 16'd5, 12, -1, -1);
        check("t2_nrd", 32'(n_rd), 32'd5);
        check("t2_nwr", 32'(n_wr), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_rd_addr[%0d]", i), 32'(rd_addr[i]), 32'(t2_rd[i]));
            check($sformatf("t2_wr_cyc[%0d]", i),  32'(wr_c[i]),    32'(4 + i));
            check($sformatf("t2_wr_sel[%0d]", i),  32'(wr_sel[i]),  32'(t2_sel[i]));
            check($sformatf("t2_wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(t2_addr[i]));
            check($sformatf("t2_wr_data[%0d]", i), 32'(wr_data[i]), 32'(t2_data[i]));
        end
        check("t2_done_cyc", 32'(done_c), 32'd9);
        check("t2_busy_c8",  32'(busy_log[8]), 32'd1);
        check("t2_busy_c9",  32'(busy_log[9]), 32'd0);

        // Default config, conv + FC
        run(1'b0, 16'h0100, 16'd3, 16'd8, 15, -1, -1);
        check("t1_nrd", 32'(n_rd), 32'd11);
        check("t1_nwr", 32'(n_wr), 32'd11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t1_rd_addr[%0d]", i), 32'(rd_addr[i]), 32'(16'h0100 + 16'(i)));
            check($sformatf("t1_rd_cyc[%0d]", i),  32'(rd_c[i]),    32'(1 + i));
            check($sformatf("t1_wr_cyc[%0d]", i),  32'(wr_c[i]),    32'(2 + i));
            check($sformatf("t1_wr_sel[%0d]", i),  32'(wr_sel[i]),  32'(t1_sel[i]));
            check($sformatf("t1_wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(t1_addr[i]));
            check($sformatf("t1_wr_data[%0d]", i), 32'(wr_data[i]), 32'((16'h0100 + 16'(i)) ^ 16'hA5A5));
        end
        check("t1_done_cyc", 32'(done_c), 32'd13);
        check("t1_busy_c1",  32'(busy_log[1]),  32'd1);
        check("t1_busy_c13", 32'(busy_log[13]), 32'd0);

        // Start pulsed mid-transfer has no effect
        run(1'b0, 16'h0100, 16'd3, 16'd8, 15, -1, 4);
        check("t6_mid_start_nrd",  32'(n_rd),       32'd11);
        check("t6_mid_start_last", 32'(rd_addr[10]), 32'h010A);
        check("t6_mid_start_done", 32'(done_c),     32'd13);

        // Zero-length transfer
        run(1'b0, 16'h0040, 16'd0, 16'd0, 4, -1, -1);
        check("t3_done_cyc", 32'(done_c), 32'd1);
        check("t3_nrd",      32'(n_rd),   32'd0);
        check("t3_nwr",      32'(n_wr),   32'd0);
        check("t3_busy_c1",  32'(busy_log[1]), 32'd0);

        // Length overflow
        run(1'b0, 16'h0010, 16'd2049, 16'd0, 4, -1, -1);
        check("t4_conv_err",  32'(err1),   32'd1);
        check("t4_conv_nrd",  32'(n_rd),   32'd0);
        check("t4_conv_done", 32'(done_c), 32'd0);
        run(1'b0, 16'h0010, 16'd0, 16'd8193, 4, -1, -1);
        check("t4_fc_err",    32'(err1),   32'd1);
        check("t4_fc_nrd",    32'(n_rd),   32'd0);
        check("t4_fc_done",   32'(done_c), 32'd0);
        check("t4_err_sticky", 32'(s_err), 32'd1);
        run(1'b0, 16'h0300, 16'd1, 16'd1, 6, -1, -1);
        check("t4_err_cleared", 32'(err1),      32'd0);
        check("t4_valid_done",  32'(done_c),    32'd4);
        check("t4_valid_nwr",   32'(n_wr),      32'd2);
        check("t4_valid_sel0",  32'(wr_sel[0]), 32'd1);
        check("t4_valid_sel1",  32'(wr_sel[1]), 32'd2);

        // Largest legal lengths are accepted (aborted early)
        run(1'b0, 16'h0000, 16'd2048, 16'd0, 4, 2, -1);
        check("bnd_conv_err",  32'(err1),        32'd0);
        check("bnd_conv_busy", 32'(busy_log[1]), 32'd1);
        check("bnd_conv_nrd",  32'(n_rd),        32'd2);
        run(1'b0, 16'h0000, 16'd0, 16'd8192, 4, 2, -1);
        check("bnd_fc_err",    32'(err1),        32'd0);
        check("bnd_fc_nrd",    32'(n_rd),        32'd2);

        // Abort at cycle 5 of a 20-word transfer, then restart
        run(1'b0, 16'h0200, 16'd10, 16'd10, 6, 5, -1);
        check("t5_abort_nrd",     32'(n_rd),        32'd5);
        check("t5_abort_nwr",     32'(n_wr),        32'd4);
        check("t5_abort_last_wr", 32'(wr_c[3]),     32'd5);
        check("t5_abort_busy_c6", 32'(busy_log[6]), 32'd0);
        check("t5_abort_done",    32'(done_c),      32'd0);
        check("t5_abort_err",     32'(s_err),       32'd0);
        run(1'b0, 16'h0200, 16'd10, 16'd10, 25, -1, -1);
        check("t5_re_nrd", 32'(n_rd), 32'd20);
        check("t5_re_nwr", 32'(n_wr), 32'd20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t5_wr_sel[%0d]", i),  32'(wr_sel[i]),  32'(t5_sel[i]));
            check($sformatf("t5_wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(t5_addr[i]));
            check($sformatf("t5_wr_data[%0d]", i), 32'(wr_data[i]), 32'((16'h0200 + 16'(i)) ^ 16'hA5A5));
        end
        check("t5_re_done", 32'(done_c), 32'd22);

        // Start and abort in the same idle cycle: abort wins
        run(1'b0, 16'h0100, 16'd3, 16'd8, 5, 0, -1);
        check("t6_sa_nrd",  32'(n_rd),        32'd0);
        check("t6_sa_busy", 32'(busy_log[1]), 32'd0);
        check("t6_sa_done", 32'(done_c),      32'd0);

        // Asynchronous reset in the middle of a transfer
        run(1'b0, 16'h0100, 16'd3, 16'd8, 4, -1, -1);
        check("t6_pre_rst_busy", 32'(s_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_rd",    32'(s_rd),    32'd0);
        check("t6_rst_we",    32'(s_we),    32'd0);
        check("t6_rst_addr",  32'(s_addr),  32'd0);
        check("t6_rst_sel",   32'(s_sel),   32'd0);
        check("t6_rst_waddr", 32'(s_waddr), 32'd0);
        check("t6_rst_wdata", 32'(s_wdata), 32'd0);
        check("t6_rst_busy",  32'(s_busy),  32'd0);
        check("t6_rst_done",  32'(s_done),  32'd0);
        check("t6_rst_err",   32'(s_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 16'h0000, 16'd0, 16'd0, 3, -1, -1);
        check("t6_post_rst_done", 32'(done_c), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_dma_multibank.md
Name: weight_dma_multibank

Overview:
- Parametrised successor to the fixed conv/4×FC weight DMA in the CNN accelerator top.
- Streams weights from the ITCM/source SRAM into one conv weight bank plus NUM_FC_BANKS FC weight banks.
- Conv and FC lengths and source base address are run-time inputs, not constants.
- Adds abort, length-overflow error, configurable source read latency, and one-hot bank select replacing the per-bank control bits.

Parameters:
DW, 16, data word width
AW, 16, source address and length width
NUM_FC_BANKS, 4, number of FC weight banks (1..8)
BANK_AW, 11, per-bank address width
RD_LAT, 1, source read latency in cycles (1..3)

Ports:
i_clk  in  1  single clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle start request; sampled only in IDLE
i_abort  in  1  one-cycle abort request
i_src_base  in  AW  source start address, captured at start
i_conv_len  in  AW  conv word count, captured at start
i_fc_len  in  AW  total FC word count, captured at start
o_src_addr  out  AW  source read address
o_src_rd  out  1  source read strobe
i_src_data  in  DW  source read data, valid RD_LAT cycles after o_src_rd
o_wr_en  out  1  bank write strobe
o_wr_sel  out  NUM_FC_BANKS+1  one-hot bank select; bit0 = conv, bit k = FC bank k-1
o_wr_addr  out  BANK_AW  bank write address
o_wr_data  out  DW  bank write data
o_busy  out  1  high from the cycle after accepted start until DONE or IDLE
o_done  out  1  level; high from completion until the next accepted start
o_err  out  1  level; sticky length-overflow flag, cleared on the next accepted start

Behaviour:
- Reset: all outputs 0; FSM = IDLE; the read-tag pipeline is cleared.
- FSM states: IDLE, CONV, FC, DRAIN, DONE. DONE behaves as IDLE, except o_done = 1.
- Start (edge 0, state IDLE or DONE): capture inputs, clear o_done and o_err.
- Overflow check at start:
  - Overflow if conv_len > 2^BANK_AW, or ceil(fc_len / NUM_FC_BANKS) > 2^BANK_AW.
  - On overflow: o_err = 1 from cycle 1, FSM returns to IDLE, no reads issued, o_done stays 0.
- Next state after start: CONV if conv_len > 0; else FC if fc_len > 0; else DONE, with o_done = 1 at cycle 1.
- Reads:
  - One per cycle, back-to-back, starting at cycle 1.
  - o_src_addr = base + i, for i = 0 .. conv_len+fc_len-1, with AW wrap-around.
  - CONV issues conv_len reads; FC issues fc_len reads; then DRAIN.
- Tag pipeline: each read carries {sel, addr} through an RD_LAT-deep pipeline, aligned with i_src_data.
  - Conv word j: sel bit0, addr j.
  - FC word k: sel bit (1 + k mod NUM_FC_BANKS), addr floor(k / NUM_FC_BANKS).
  - Modulo and divide are implemented as rotating counters; no dividers.
- Writes: o_wr_en, o_wr_sel, o_wr_addr and o_wr_data are asserted RD_LAT cycles after the corresponding o_src_rd. o_wr_data = i_src_data.
- DRAIN: wait until the pipeline is empty, then go to DONE.
  - o_done rises exactly conv_len + fc_len + RD_LAT + 1 cycles after the start edge.
  - o_busy falls in the same cycle.
- Abort (any state):
  - o_src_rd drops the next cycle.
  - In-flight pipeline entries are discarded, so o_wr_en = 0 from the next cycle.
  - FSM goes to IDLE; o_done = 0 and o_err = 0.
  - Abort together with start in IDLE: abort wins and the start is ignored.
- i_start while busy: ignored, with no effect on counters.
- Asynchronous reset mid-transfer: immediate return to the reset state; partially written banks are not cleaned up.
- Source and bank buses are driven only while the matching strobe is high; otherwise they hold their last value.

Decomposition:
- Shared package:
  - FSM state enum (3-bit).
  - Function computing ceil(fc_len / NUM_FC_BANKS) overflow from the parameters.
  - Localparam SEL_W = NUM_FC_BANKS + 1.
- One sub-module: wdma_tag_pipe.
  - RD_LAT-stage shift register of {valid, sel, addr}.
  - Has a synchronous flush input, driven by abort.
  - Reports an empty flag to the FSM.

Test Plan:
1. Default parameters, base = 0x0100, conv_len = 3, fc_len = 8:
   - Reads at 0x0100..0x010A.
   - Writes: conv addr 0..2; bank1 addr 0,1 gets words 0,4; bank2 gets words 1,5; bank3 gets 2,6; bank4 gets 3,7.
   - o_done at cycle 13.
2. RD_LAT = 3, conv_len = 0, fc_len = 5, base = 0xFFFE:
   - Addresses wrap 0xFFFE, 0xFFFF, 0x0000..0x0002.
   - Bank1 receives addr 0 and addr 1.
   - o_done at cycle 9.
3. conv_len = 0 and fc_len = 0:
   - o_done = 1 at cycle 1.
   - No o_src_rd or o_wr_en pulses.
4. Overflow cases:
   - conv_len = 2049, or fc_len = 8193 with NUM_FC_BANKS = 4.
   - Required: o_err = 1, zero reads, o_done = 0.
   - A following valid start clears o_err.
5. Abort at cycle 5 of a 20-word transfer:
   - No o_wr_en from cycle 6.
   - FSM back in IDLE; o_done = 0.
   - A start 2 cycles later runs the full transfer correctly.
6. Interference during and after a transfer:
   - i_start pulsed mid-transfer is ignored.
   - i_rst asserted mid-transfer clears all outputs asynchronously.
   - Start with abort in the same IDLE cycle produces no reads.
